rot_seq_ctrl: RTL and testbench
===============================

Name: rot_seq_ctrl

Overview:
Parametrised sequencer for the serial-to-parallel rotation datapath. On each "parallel word ready" pulse it loads the word through the input mux, then steps a rotation amount for a configurable number of rounds in either direction, and finally asserts the demux strobe to release the result. A one-deep request queue supports back-to-back words, and overflow beyond that queue is flagged.

Parameters:
ROT_W, 3, width of the rotation output; rotation arithmetic is modulo 2^ROT_W.
ROUNDS, 8, rotation cycles per word; legal range is ROUNDS >= 1.
ROT_STEP, 1, increment or decrement applied to rotation each round; legal range is 1 <= ROT_STEP < 2^ROT_W.

Ports:
clk  in  1  system clock; all flops are rising-edge.
rst  in  1  asynchronous, active-high reset.
s_p_flag_in  in  1  single-cycle pulse meaning a parallel word is ready.
dir  in  1  rotation direction, sampled together with s_p_flag_in; 0 counts up, 1 counts down.
mux_flag  out  1  1 selects the new word into the datapath; 0 selects feedback.
rotation  out  ROT_W  current rotation amount.
demux_flag  out  1  result-valid strobe, one cycle per word.
busy  out  1  high while a word is in flight (LOAD, ROTATE or FLUSH).
overrun  out  1  one-cycle pulse when a request is dropped.

Behaviour:
- One clock domain. Reset is asynchronous and active-high.
- While rst is high, all outputs are 0: mux_flag, rotation, demux_flag, busy, overrun. The state goes to IDLE, and the pending slot and round counter are cleared.
- All outputs are registered (Moore). There is no combinational path from input to output.
- States: IDLE, LOAD, ROTATE, FLUSH.
- IDLE:
  - Outputs are all 0.
  - s_p_flag_in=1 moves to LOAD and latches dir into cur_dir.
- LOAD (1 cycle):
  - mux_flag=1, rotation=0, busy=1.
  - Always moves to ROTATE and sets the round counter to 1.
- ROTATE (exactly ROUNDS cycles):
  - mux_flag=0, busy=1.
  - In round k (k = 1..ROUNDS), rotation = (k*ROT_STEP) mod 2^ROT_W when cur_dir=0, and (-(k*ROT_STEP)) mod 2^ROT_W when cur_dir=1.
  - Wrap-around is silent.
  - After round ROUNDS, moves to FLUSH.
- FLUSH (1 cycle):
  - demux_flag=1, busy=1, mux_flag=0.
  - rotation holds its round-ROUNDS value.
  - Next state is LOAD if the pending slot is set or s_p_flag_in=1; otherwise IDLE.
- Latency and throughput:
  - s_p_flag_in sampled at edge 0 gives mux_flag=1 in the cycle after edge 0.
  - demux_flag rises ROUNDS+1 cycles after mux_flag.
  - Sustained throughput is one word per ROUNDS+2 cycles, with no idle gap between words.
- Pending slot (one deep) while busy:
  - s_p_flag_in=1 with the slot empty: the slot is set and dir is captured into pend_dir.
  - s_p_flag_in=1 with the slot full: the request is dropped and overrun pulses high for the next cycle. The slot contents are unchanged.
- Entering LOAD from FLUSH:
  - If the slot is set, cur_dir takes pend_dir and the slot is cleared. A same-cycle s_p_flag_in then refills the slot with the new dir, so no overrun.
  - If the slot is empty and s_p_flag_in=1, cur_dir takes dir directly.
- ROUNDS=1: ROTATE lasts a single cycle; the sequence is LOAD, one ROTATE cycle, FLUSH.
- Reset asserted mid-operation: aborts immediately and asynchronously with all outputs 0. Any pending request is lost. After rst is released, the block waits in IDLE for a new s_p_flag_in.
- Round counter width is clog2(ROUNDS+1). Rotation arithmetic is truncated to ROT_W bits.

Test Plan:
- Reset check: rst=1 at time 0, clocks running, s_p_flag_in toggling -> every output stays 0. After release with no pulse, it stays IDLE: busy=0, rotation=0.
- Single word, defaults, dir=0, one pulse -> mux_flag=1 for 1 cycle; rotation steps 1,2,3,4,5,6,7,0 over 8 cycles; demux_flag=1 for 1 cycle in cycle 10; busy high for exactly 10 cycles; overrun=0.
- Down count, dir=1, ROT_STEP=3 -> rotation sequence 5,2,7,4,1,6,3,0; demux_flag then occurs in cycle 10.
- Back-to-back: second pulse (dir=1) during ROTATE of a dir=0 word -> the cycle after the first demux_flag has mux_flag=1; second word counts down; busy never drops between words; overrun=0.
- Overrun: three pulses, 2nd and 3rd both during the first word's ROTATE -> exactly one overrun pulse, the cycle after the 3rd pulse; exactly two demux_flag pulses in total.
- Mid-op reset: rst=1 while rotation=4 in ROTATE with the pending slot set -> all outputs 0 without waiting for a clock edge; after release, no LOAD occurs until a new s_p_flag_in.

Source files
------------

// File: rtl/rot_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rot_seq_ctrl
//  Purpose  : Sequencer for the serial-to-parallel rotation datapath. Each
//             "parallel word ready" pulse loads a word through the input
//             mux. The rotation amount is then stepped up or down for ROUNDS
//             cycles, and a single demux strobe releases the result. A
//             one-deep pending slot accepts back-to-back words, and a request
//             that arrives while the slot is full is dropped and flagged.
//  Ports    : clk          - system clock, rising edge
//             rst          - asynchronous active-high reset
//             s_p_flag_in  - single-cycle "parallel word ready" pulse
//             dir          - direction sampled with s_p_flag_in (0 up, 1 down)
//             mux_flag     - 1 selects the new word, 0 selects feedback
//             rotation     - current rotation amount (mod 2^ROT_W)
//             demux_flag   - one-cycle result-valid strobe per word
//             busy         - word in flight (LOAD, ROTATE or FLUSH)
//             overrun      - one-cycle pulse when a request is dropped
//  Revision : 1.0 - initial release
// ============================================================================
module rot_seq_ctrl #(
    parameter int ROT_W    = 3,
    parameter int ROUNDS   = 8,
    parameter int ROT_STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_p_flag_in,
    input  logic             dir,
    output logic             mux_flag,
    output logic [ROT_W-1:0] rotation,
    output logic             demux_flag,
    output logic             busy,
    output logic             overrun
);

    localparam int               CNT_W    = $clog2(ROUNDS + 1);
    localparam logic [CNT_W-1:0] c_ROUNDS = CNT_W'(ROUNDS);
    localparam logic [ROT_W-1:0] c_STEP   = ROT_W'(ROT_STEP);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ROTATE = 2'd2,
        ST_FLUSH  = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cur_dir;
    logic             r_pend;
    logic             r_pend_dir;
    logic             r_mux;
    logic [ROT_W-1:0] r_rot;
    logic             r_demux;
    logic             r_busy;
    logic             r_overrun;

    // Rotation is 0 while in LOAD. The same step expression therefore
    // produces round 1 on leaving LOAD and every later round in ROTATE.
    // Wrap-around is plain modulo truncation.
    logic [ROT_W-1:0] w_rot_next;
    assign w_rot_next = r_cur_dir ? (r_rot - c_STEP) : (r_rot + c_STEP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_cur_dir  <= 1'b0;
            r_pend     <= 1'b0;
            r_pend_dir <= 1'b0;
            r_mux      <= 1'b0;
            r_rot      <= '0;
            r_demux    <= 1'b0;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_overrun <= 1'b0;

            // Pending-slot capture while mid-word. FLUSH manages the slot
            // itself, because it may consume and refill the slot in the
            // same cycle.
            if ((r_state == ST_LOAD || r_state == ST_ROTATE) && s_p_flag_in) begin
                if (!r_pend) begin
                    r_pend     <= 1'b1;
                    r_pend_dir <= dir;
                end else begin
                    r_overrun <= 1'b1;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (s_p_flag_in) begin
                        r_state   <= ST_LOAD;
                        r_cur_dir <= dir;
                        r_mux     <= 1'b1;
                        r_rot     <= '0;
                        r_busy    <= 1'b1;
                        r_demux   <= 1'b0;
                    end
                end

                ST_LOAD: begin
                    r_state <= ST_ROTATE;
                    r_cnt   <= CNT_W'(1);
                    r_mux   <= 1'b0;
                    r_rot   <= w_rot_next;
                end

                ST_ROTATE: begin
                    if (r_cnt == c_ROUNDS) begin
                        // Rotation holds its final-round value through FLUSH.
                        r_state <= ST_FLUSH;
                        r_demux <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        r_rot <= w_rot_next;
                    end
                end

                ST_FLUSH: begin
                    r_demux <= 1'b0;
                    if (r_pend || s_p_flag_in) begin
                        r_state   <= ST_LOAD;
                        r_mux     <= 1'b1;
                        r_rot     <= '0;
                        // The queued request is served first. A same-cycle
                        // pulse refills the slot just freed, so it is not an
                        // overrun.
                        r_cur_dir <= r_pend ? r_pend_dir : dir;
                        r_pend    <= r_pend && s_p_flag_in;
                        if (r_pend && s_p_flag_in) begin
                            r_pend_dir <= dir;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                        r_rot   <= '0;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_mux   <= 1'b0;
                    r_rot   <= '0;
                    r_demux <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign mux_flag   = r_mux;
    assign rotation   = r_rot;
    assign demux_flag = r_demux;
    assign busy       = r_busy;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_rot_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rot_seq_ctrl
//  Purpose  : Directed self-checking bench for rot_seq_ctrl. It uses three
//             instances: the default parameters, ROT_STEP=3, and ROUNDS=1.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rot_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // Instance A: defaults
    logic       a_flag = 1'b0, a_dir = 1'b0;
    logic       a_mux, a_demux, a_busy, a_ovr;
    logic [2:0] a_rot;
    // Instance B: ROT_STEP = 3
    logic       b_flag = 1'b0, b_dir = 1'b0;
    logic       b_mux, b_demux, b_busy, b_ovr;
    logic [2:0] b_rot;
    // Instance C: ROUNDS = 1
    logic       c_flag = 1'b0, c_dir = 1'b0;
    logic       c_mux, c_demux, c_busy, c_ovr;
    logic [2:0] c_rot;

    rot_seq_ctrl u_dut_a (
        .clk(clk), .rst(rst), .s_p_flag_in(a_flag), .dir(a_dir),
        .mux_flag(a_mux), .rotation(a_rot), .demux_flag(a_demux),
        .busy(a_busy), .overrun(a_ovr)
    );

    rot_seq_ctrl #(.ROT_W(3), .ROUNDS(8), .ROT_STEP(3)) u_dut_b (
        .clk(clk), .rst(rst), .s_p_flag_in(b_flag), .dir(b_dir),
        .mux_flag(b_mux), .rotation(b_rot), .demux_flag(b_demux),
        .busy(b_busy), .overrun(b_ovr)
    );

    rot_seq_ctrl #(.ROT_W(3), .ROUNDS(1), .ROT_STEP(1)) u_dut_c (
        .clk(clk), .rst(rst), .s_p_flag_in(c_flag), .dir(c_dir),
        .mux_flag(c_mux), .rotation(c_rot), .demux_flag(c_demux),
        .busy(c_busy), .overrun(c_ovr)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Packed as {mux, demux, busy, overrun, rotation[2:0]}
    function automatic logic [31:0] pk(input logic m, input logic d, input logic b,
                                       input logic o, input logic [2:0] r);
        return {25'd0, m, d, b, o, r};
    endfunction

    logic [2:0] up1  [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    logic [2:0] dn3  [8] = '{3'd5, 3'd2, 3'd7, 3'd4, 3'd1, 3'd6, 3'd3, 3'd0};
    logic [2:0] dn1  [8] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

    initial begin
        int         demux_cnt;
        int         ovr_cnt;
        logic [2:0] rot12;
        logic       any_act;

        // ---------------- reset held, pulses toggling ----------------
        for (int i = 0; i < 4; i++) begin
            a_flag = i[0]; b_flag = i[0]; c_flag = i[0];
            tick();
            chk("rst_hold_a", pk(a_mux, a_demux, a_busy, a_ovr, a_rot), pk(0, 0, 0, 0, 3'd0));
        end
        chk("rst_hold_b", pk(b_mux, b_demux, b_busy, b_ovr, b_rot), pk(0, 0, 0, 0, 3'd0));
        a_flag = 0; b_flag = 0; c_flag = 0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("idle_after_rst", pk(a_mux, a_demux, a_busy, a_ovr, a_rot), pk(0, 0, 0, 0, 3'd0));

        // ---------------- single word, up, step 1 ----------------
        a_flag = 1; a_dir = 0;
        tick();
        a_flag = 0;
        chk("s_load", pk(a_mux, a_demux, a_busy, a_ovr, a_rot), pk(1, 0, 1, 0, 3'd0));
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("s_round", pk(a_mux, a_demux, a_busy, a_ovr, a_rot), pk(0, 0, 1, 0, up1[k]));
        end
        tick();
        chk("s_flush", pk(a_mux, a_demux, a_busy, a_ovr, a_rot), pk(0, 1, 1, 0, 3'd0));
        tick();
        chk("s_idle", pk(a_mux, a_demux, a_busy, a_ovr, a_rot), pk(0, 0, 0, 0, 3'd0));

        // ---------------- down count, step 3 ----------------
        b_flag = 1; b_dir = 1;
        tick();
        b_flag = 0;
        chk("d_load", pk(b_mux, b_demux, b_busy, b_ovr, b_rot), pk(1, 0, 1, 0, 3'd0));
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("d_round", pk(b_mux, b_demux, b_busy, b_ovr, b_rot), pk(0, 0, 1, 0, dn3[k]));
        end
        tick();
        chk("d_flush", pk(b_mux, b_demux, b_busy, b_ovr, b_rot), pk(0, 1, 1, 0, 3'd0));
        tick();
        chk("d_idle", pk(b_mux, b_demux, b_busy, b_ovr, b_rot), pk(0, 0, 0, 0, 3'd0));

        // ---------------- ROUNDS = 1 ----------------
        c_flag = 1; c_dir = 0;
        tick();
        c_flag = 0;
        chk("r1_load", pk(c_mux, c_demux, c_busy, c_ovr, c_rot), pk(1, 0, 1, 0, 3'd0));
        tick();
        chk("r1_round", pk(c_mux, c_demux, c_busy, c_ovr, c_rot), pk(0, 0, 1, 0, 3'd1));
        tick();
        chk("r1_flush", pk(c_mux, c_demux, c_busy, c_ovr, c_rot), pk(0, 1, 1, 0, 3'd1));
        tick();
        chk("r1_idle", pk(c_mux, c_demux, c_busy, c_ovr, c_rot), pk(0, 0, 0, 0, 3'd0));

        // ---------------- back-to-back ----------------
        a_flag = 1; a_dir = 0;
        tick();
        a_flag = 0;
        chk("bb_load1", pk(a_mux, a_demux, a_busy, a_ovr, a_rot), pk(1, 0, 1, 0, 3'd0));
        tick();
        chk("bb_r1", pk(a_mux, a_demux, a_busy, a_ovr, a_rot), pk(0, 0, 1, 0, 3'd1));
        a_flag = 1; a_dir = 1;
        tick();
        a_flag = 0; a_dir = 0;
        chk("bb_r2", pk(a_mux, a_demux, a_busy, a_ovr, a_rot), pk(0, 0, 1, 0, 3'd2));
        for (int k = 2; k < 8; k++) begin
            tick();
            chk("bb_w1", pk(a_mux, a_demux, a_busy, a_ovr, a_rot), pk(0, 0, 1, 0, up1[k]));
        end
        tick();
        chk("bb_flush1", pk(a_mux, a_demux, a_busy, a_ovr, a_rot), pk(0, 1, 1, 0, 3'd0));
        tick();
        chk("bb_load2", pk(a_mux, a_demux, a_busy, a_ovr, a_rot), pk(1, 0, 1, 0, 3'd0));
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("bb_w2", pk(a_mux, a_demux, a_busy, a_ovr, a_rot), pk(0, 0, 1, 0, dn1[k]));
        end
        tick();
        chk("bb_flush2", pk(a_mux, a_demux, a_busy, a_ovr, a_rot), pk(0, 1, 1, 0, 3'd0));
        tick();
        chk("bb_idle", pk(a_mux, a_demux, a_busy, a_ovr, a_rot), pk(0, 0, 0, 0, 3'd0));

        // ---------------- overrun ----------------
        a_flag = 1; a_dir = 0;
        tick();                       // cycle 1: LOAD
        a_flag = 0;
        tick();                       // cycle 2: round 1
        a_flag = 1; a_dir = 1;        // 2nd pulse -> pending slot
        tick();                       // cycle 3
        chk("ov_none_yet", {31'd0, a_ovr}, 32'd0);
        a_dir = 0;                    // 3rd pulse -> dropped
        tick();                       // cycle 4
        a_flag = 0;
        chk("ov_pulse", {31'd0, a_ovr}, 32'd1);
        ovr_cnt   = 1;
        demux_cnt = 0;
        rot12     = 3'd0;
        for (int cyc = 5; cyc <= 30; cyc++) begin
            tick();
            if (a_ovr)   ovr_cnt++;
            if (a_demux) demux_cnt++;
            if (cyc == 12) rot12 = a_rot;
        end
        chk("ov_count", ovr_cnt, 32'd1);
        chk("ov_demux_count", demux_cnt, 32'd2);
        chk("ov_pend_dir_kept", {29'd0, rot12}, 32'd7);
        chk("ov_idle", {31'd0, a_busy}, 32'd0);

        // ---------------- mid-operation reset ----------------
        a_flag = 1; a_dir = 0;
        tick();                       // cycle 1: LOAD
        a_flag = 0;
        tick();                       // cycle 2: rot 1
        a_flag = 1; a_dir = 1;        // fill the pending slot
        tick();                       // cycle 3: rot 2
        a_flag = 0;
        tick();                       // cycle 4: rot 3
        tick();                       // cycle 5: rot 4
        chk("mr_pre", pk(a_mux, a_demux, a_busy, a_ovr, a_rot), pk(0, 0, 1, 0, 3'd4));
        #2 rst = 1'b1;
        #1;
        chk("mr_async", pk(a_mux, a_demux, a_busy, a_ovr, a_rot), pk(0, 0, 0, 0, 3'd0));
        tick();
        rst = 1'b0;
        any_act = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (a_mux || a_busy || a_demux) any_act = 1'b1;
        end
        chk("mr_no_load", {31'd0, any_act}, 32'd0);
        a_flag = 1; a_dir = 1;
        tick();
        a_flag = 0;
        chk("mr_new_load", pk(a_mux, a_demux, a_busy, a_ovr, a_rot), pk(1, 0, 1, 0, 3'd0));
        tick();
        chk("mr_new_r1", pk(a_mux, a_demux, a_busy, a_ovr, a_rot), pk(0, 0, 1, 0, 3'd7));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
